sr_latch_driver: RTL

Synchronous command-side driver for the cross-coupled NOR SR latch. It converts a single-cycle write request (target level `d`) into a guarded, non-overlapping set or reset pulse of fixed width. It then reads the latch's `q`/`qb` back through a synchronizer and reports pass or fail. It sits between clocked control logic and the asynchronous latch cell, so the latch never sees `s` and `r` high together or a runt pulse.

---
 rtl/sr_latch_driver.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// Command-side driver for a cross-coupled NOR SR latch.
// Emits guarded set/reset pulses and checks synchronized readback.
module sr_latch_driver #(
  parameter int GAP_W   = 2,
  parameter int PULSE_W = 4,
  parameter int SETTLE  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic d,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qb_fb,
  output logic busy,
  output logic done,
  output logic err,
  output logic level
);

  localparam int MAX_GP = (GAP_W > PULSE_W) ? GAP_W : PULSE_W;
  localparam int MAXC   = (MAX_GP > SETTLE) ? MAX_GP : SETTLE;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETL_LD  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    PULSE,
    SETL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tgt;
  logic          q1;
  logic          qb1;
  logic          qs;
  logic          qbs;
  logic          pass;

  // Both rails must agree with the target; equal rails never pass.
  assign pass = (qs == tgt) && (qbs == ~tgt);

  always_ff @(posedge clk) begin
    if (rst) begin
      q1  <= 1'b0;
      qb1 <= 1'b0;
      qs  <= 1'b0;
      qbs <= 1'b0;
    end else begin
      q1  <= q_fb;
      qb1 <= qb_fb;
      qs  <= q1;
      qbs <= qb1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tgt   <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      level <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            tgt   <= d;
            level <= d;
            busy  <= 1'b1;
            cnt   <= GAP_LD;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            s     <= tgt;
            r     <= ~tgt;
            cnt   <= PULSE_LD;
            state <= PULSE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            cnt   <= SETL_LD;
            state <= SETL;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        SETL: begin
          if (cnt == '0) begin
            err   <= ~pass;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
